// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the fixed-latency data-memory responder.
package pkg_dmem_resp;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam int unsigned REQ_DW   = 32;
  localparam int unsigned LAT_W    = 4;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  typedef struct packed {
    logic              write;
    logic [REQ_DW-1:0] addr;
    logic [REQ_DW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_responder_array.sv
// Single-port word array with a registered read; a read and a write to the
// same index in one cycle returns the old contents.
module dmem_array #(
  parameter int unsigned DWidth = 32,
  parameter int unsigned Depth  = 4096
) (
  input  logic                     clk_i,
  input  logic                     we,
  input  logic [$clog2(Depth)-1:0] idx,
  input  logic [DWidth-1:0]        wdata,
  output logic [DWidth-1:0]        rdata
);

  logic [DWidth-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: captures one request, answers it Latency cycles later
// with a one-cycle ready pulse, and counts completed reads and writes.
module dmem_responder
  import pkg_dmem_resp::*;
#(
  parameter int unsigned       DWidth   = REQ_DW,
  parameter int unsigned       Depth    = 4096,
  parameter logic [DWidth-1:0] BaseAddr = 32'h0000_4000,
  parameter int unsigned       Latency  = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              write_i,
  input  logic [DWidth-1:0] addr_i,
  input  logic [DWidth-1:0] wdata_i,
  output logic              ready_o,
  output logic [DWidth-1:0] rdata_o,
  output logic              err_o,
  output logic [31:0]       rd_cnt_o,
  output logic [31:0]       wr_cnt_o
);

  localparam int unsigned IdxW = $clog2(Depth);

  state_e            state_reg, state_next;
  logic [LAT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  req_t              req_reg, req_next;
  logic              ready_reg;
  logic              err_reg;
  logic [DWidth-1:0] rdata_reg;
  logic [31:0]       rd_cnt_reg;
  logic [31:0]       wr_cnt_reg;

  logic              req_hit;
  logic              arr_we;
  logic [IdxW-1:0]   arr_idx;
  logic [DWidth-1:0] arr_rdata;

  function automatic logic addr_hit(input logic [DWidth-1:0] a);
    logic [DWidth-1:0] off;
    off = a - BaseAddr;
    return (a >= BaseAddr) && (off[1:0] == 2'b00) && ((off >> 2) < DWidth'(Depth));
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [DWidth-1:0] a);
    logic [DWidth-1:0] off;
    off = (a - BaseAddr) >> 2;
    return off[IdxW-1:0];
  endfunction

  assign req_hit = addr_hit(req_reg.addr);

  // In IDLE the array is addressed straight from the bus so a Latency=1 read
  // has its data ready in the response cycle; otherwise the captured address
  // is used, and the last WAIT-cycle read is the one that lands with ready_o.
  assign arr_idx = (state_reg == S_IDLE) ? word_idx(addr_i) : word_idx(req_reg.addr);
  assign arr_we  = rst_ni && (state_reg == S_RESP) && req_reg.write && req_hit;

  dmem_array #(
    .DWidth(DWidth),
    .Depth (Depth)
  ) u_array (
    .clk_i(clk_i),
    .we   (arr_we),
    .idx  (arr_idx),
    .wdata(req_reg.wdata),
    .rdata(arr_rdata)
  );

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    req_next      = req_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (req_i) begin
          req_next = '{write: write_i, addr: addr_i, wdata: wdata_i};
          if (Latency > 1) begin
            state_next    = S_WAIT;
            wait_cnt_next = LAT_W'(Latency) - LAT_W'(2);
          end else begin
            state_next = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt_reg == '0) begin
          state_next = S_RESP;
        end else begin
          wait_cnt_next = wait_cnt_reg - LAT_W'(1);
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
      req_reg      <= '0;
      ready_reg    <= 1'b0;
      err_reg      <= 1'b0;
      rdata_reg    <= '0;
      rd_cnt_reg   <= '0;
      wr_cnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      req_reg      <= req_next;
      ready_reg    <= (state_reg == S_RESP);
      if (state_reg == S_RESP) begin
        err_reg <= !req_hit;
        if (req_reg.write) begin
          wr_cnt_reg <= wr_cnt_reg + 32'd1;
        end else begin
          rd_cnt_reg <= rd_cnt_reg + 32'd1;
          rdata_reg  <= req_hit ? arr_rdata : DWidth'(ERR_DATA);
        end
      end
    end
  end

  assign ready_o  = ready_reg;
  assign err_o    = err_reg;
  assign rdata_o  = rdata_reg;
  assign rd_cnt_o = rd_cnt_reg;
  assign wr_cnt_o = wr_cnt_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (Latency 2, 1, 5) checked every
// cycle against a countdown-and-scoreboard model, plus directed literal checks.
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h0000_4000;
  localparam int          DEPTH = 4096;
  localparam int          LAT [3] = '{2, 1, 5};

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [3];
  logic        req   [3];
  logic        wr    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        ready [3];
  logic        err   [3];
  logic [31:0] rdata [3];
  logic [31:0] rd_cnt[3];
  logic [31:0] wr_cnt[3];

  dmem_responder #(.Latency(2)) u_dut_l2 (
    .clk_i(clk), .rst_ni(rst_n[0]), .req_i(req[0]), .write_i(wr[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .ready_o(ready[0]), .rdata_o(rdata[0]), .err_o(err[0]),
    .rd_cnt_o(rd_cnt[0]), .wr_cnt_o(wr_cnt[0]));

  dmem_responder #(.Latency(1)) u_dut_l1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .req_i(req[1]), .write_i(wr[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .ready_o(ready[1]), .rdata_o(rdata[1]), .err_o(err[1]),
    .rd_cnt_o(rd_cnt[1]), .wr_cnt_o(wr_cnt[1]));

  dmem_responder #(.Latency(5)) u_dut_l5 (
    .clk_i(clk), .rst_ni(rst_n[2]), .req_i(req[2]), .write_i(wr[2]), .addr_i(addr[2]),
    .wdata_i(wdata[2]), .ready_o(ready[2]), .rdata_o(rdata[2]), .err_o(err[2]),
    .rd_cnt_o(rd_cnt[2]), .wr_cnt_o(wr_cnt[2]));

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  task automatic cmp(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got %h, expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mem_m [int];          // key = instance*8192 + word index
  bit          busy  [3];
  int          left  [3];
  bit          c_w   [3];
  logic [31:0] c_a   [3];
  logic [31:0] c_d   [3];
  bit          e_ready[3];
  bit          e_err  [3];
  bit          e_known[3];
  logic [31:0] e_rdata[3];
  logic [31:0] e_rd   [3];
  logic [31:0] e_wr   [3];
  logic [31:0] wr_bias[3];           // owned by the stimulus; accounts for a forced counter

  function automatic bit m_hit(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a >= BASE) && (off % 4 == 0) && (off / 4 < DEPTH);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n[k]) begin
        busy[k] = 0; e_ready[k] = 0; e_err[k] = 0;
        e_rdata[k] = '0; e_known[k] = 1; e_rd[k] = '0; e_wr[k] = '0;
      end else begin
        e_ready[k] = 0;
        if (busy[k]) begin
          left[k]--;
          if (left[k] == 0) begin
            int key;
            busy[k] = 0;
            e_ready[k] = 1;
            e_err[k] = !m_hit(c_a[k]);
            key = k * 8192 + int'((c_a[k] - BASE) / 4);
            if (c_w[k]) begin
              e_wr[k] = e_wr[k] + 1;
              if (m_hit(c_a[k])) mem_m[key] = c_d[k];
            end else begin
              e_rd[k] = e_rd[k] + 1;
              if (!m_hit(c_a[k])) begin
                e_rdata[k] = 32'hDEADBEEF; e_known[k] = 1;
              end else if (mem_m.exists(key)) begin
                e_rdata[k] = mem_m[key]; e_known[k] = 1;
              end else begin
                e_known[k] = 0;
              end
            end
          end
        end else if (req[k]) begin
          busy[k] = 1; left[k] = LAT[k];
          c_w[k] = wr[k]; c_a[k] = addr[k]; c_d[k] = wdata[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      cmp("ready", k, 32'(ready[k]), 32'(e_ready[k]));
      cmp("rd_cnt", k, rd_cnt[k], e_rd[k]);
      cmp("wr_cnt", k, wr_cnt[k], e_wr[k] + wr_bias[k]);
      if (e_ready[k]) cmp("err", k, 32'(err[k]), 32'(e_err[k]));
      if (e_known[k]) cmp("rdata", k, rdata[k], e_rdata[k]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic xact(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input bit scramble, output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d;
    @(posedge clk);
    lat = 0;
    rd = 'x; er = 1'bx;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 0 && scramble) begin
        wr[k] = !w; addr[k] = a ^ 32'h4; wdata[k] = ~d;
      end
      if (ready[k]) begin
        rd = rdata[k]; er = err[k];
        break;
      end
      lat++;
    end
    if (lat >= 40) cmp("ready_timeout", k, 32'(lat), 32'(LAT[k]));
    req[k] = 1'b0;
  endtask

  logic [31:0] rd_v;
  logic        er_v;
  int          lat_v;
  int          pulses;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; req[k] = 1'b0; wr[k] = 1'b0;
      addr[k] = '0; wdata[k] = '0; wr_bias[k] = '0;
    end
    req[0] = 1'b1;                     // ignored while in reset
    repeat (3) @(negedge clk);
    cmp("rst_ready", 0, 32'(ready[0]), 32'd0);
    cmp("rst_rdata", 1, rdata[1], 32'd0);
    req[0] = 1'b0;
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;

    // write then read back, Latency 2
    xact(0, 1, 32'h0000_4010, 32'hCAFE_F00D, 0, rd_v, er_v, lat_v);
    cmp("t1_wlat", 0, 32'(lat_v), 32'd2);
    cmp("t1_werr", 0, 32'(er_v), 32'd0);
    xact(0, 0, 32'h0000_4010, 32'h0, 0, rd_v, er_v, lat_v);
    cmp("t1_rlat", 0, 32'(lat_v), 32'd2);
    cmp("t1_rdata", 0, rd_v, 32'hCAFE_F00D);
    cmp("t1_rerr", 0, 32'(er_v), 32'd0);
    cmp("t1_wcnt", 0, wr_cnt[0], 32'd1);
    cmp("t1_rcnt", 0, rd_cnt[0], 32'd1);

    // decode errors
    xact(0, 0, 32'h0000_3FFC, 32'h0, 0, rd_v, er_v, lat_v);
    cmp("t2_below_err", 0, 32'(er_v), 32'd1);
    cmp("t2_below_data", 0, rd_v, 32'hDEAD_BEEF);
    xact(0, 0, 32'h0000_4002, 32'h0, 0, rd_v, er_v, lat_v);
    cmp("t2_misal_err", 0, 32'(er_v), 32'd1);
    cmp("t2_misal_data", 0, rd_v, 32'hDEAD_BEEF);
    xact(0, 1, 32'h0000_7FFC, 32'h5A5A_0001, 0, rd_v, er_v, lat_v);
    cmp("t2_last_err", 0, 32'(er_v), 32'd0);
    xact(0, 1, 32'h0000_8000, 32'hFFFF_FFFF, 0, rd_v, er_v, lat_v);
    cmp("t2_over_err", 0, 32'(er_v), 32'd1);
    xact(0, 0, 32'h0000_7FFC, 32'h0, 0, rd_v, er_v, lat_v);
    cmp("t2_last_keep", 0, rd_v, 32'h5A5A_0001);

    // Latency 1, request held high across four reads
    xact(1, 1, 32'h0000_4000, 32'h0BAD_F00D, 0, rd_v, er_v, lat_v);
    cmp("t3_wlat", 1, 32'(lat_v), 32'd1);
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h0000_4000;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (ready[1]) pulses++;
    end
    req[1] = 1'b0;
    cmp("t3_pulses", 1, 32'(pulses), 32'd4);
    cmp("t3_rcnt", 1, rd_cnt[1], 32'd4);
    cmp("t3_rdata", 1, rdata[1], 32'h0BAD_F00D);

    // reset one cycle after accepting a write
    xact(0, 1, 32'h0000_4000, 32'hA5A5_A5A5, 0, rd_v, er_v, lat_v);
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_4000; wdata[0] = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    rst_n[0] = 1'b0; req[0] = 1'b0;
    @(negedge clk);
    cmp("t4_rst_ready", 0, 32'(ready[0]), 32'd0);
    rst_n[0] = 1'b1;
    @(negedge clk);
    cmp("t4_no_ready", 0, 32'(ready[0]), 32'd0);
    cmp("t4_wcnt", 0, wr_cnt[0], 32'd0);
    cmp("t4_rcnt", 0, rd_cnt[0], 32'd0);
    xact(0, 0, 32'h0000_4000, 32'h0, 0, rd_v, er_v, lat_v);
    cmp("t4_keep", 0, rd_v, 32'hA5A5_A5A5);

    // inputs change after acceptance, Latency 5
    xact(2, 1, 32'h0000_4020, 32'h1111_2222, 1, rd_v, er_v, lat_v);
    cmp("t5_wlat", 2, 32'(lat_v), 32'd5);
    xact(2, 0, 32'h0000_4020, 32'h0, 1, rd_v, er_v, lat_v);
    cmp("t5_rlat", 2, 32'(lat_v), 32'd5);
    cmp("t5_rdata", 2, rd_v, 32'h1111_2222);

    // write counter wrap
    @(posedge clk);
    #1;
    force u_dut_l2.wr_cnt_reg = 32'hFFFF_FFFF;
    wr_bias[0] = 32'hFFFF_FFFF - e_wr[0];
    #1;
    release u_dut_l2.wr_cnt_reg;
    xact(0, 1, 32'h0000_4100, 32'h0000_0001, 0, rd_v, er_v, lat_v);
    cmp("t6_wrap", 0, wr_cnt[0], 32'd0);
    cmp("t6_rcnt", 0, rd_cnt[0], 32'd1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
